// File: rtl/bit_sync_filter.sv
// Multi-channel bit synchronizer with a per-channel stability filter.
// Each channel yields a clean level plus one-cycle rise/fall pulses in the CLK domain.
module bit_sync_filter #(
  parameter int                   BUS_WIDTH  = 1,
  parameter int                   NUM_STAGES = 2,
  parameter int                   FILTER_LEN = 4,
  parameter logic [BUS_WIDTH-1:0] RST_VAL    = {BUS_WIDTH{1'b0}}
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] ASYNC,
  output logic [BUS_WIDTH-1:0] SYNC,
  output logic [BUS_WIDTH-1:0] RISE,
  output logic [BUS_WIDTH-1:0] FALL
);

  localparam int             CW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_LEN - 1);

  logic [NUM_STAGES-1:0][BUS_WIDTH-1:0] chain_q;
  logic [BUS_WIDTH-1:0][CW-1:0]         cnt_q;
  logic [BUS_WIDTH-1:0]                 sync_q;
  logic [BUS_WIDTH-1:0]                 rise_q;
  logic [BUS_WIDTH-1:0]                 fall_q;
  logic [BUS_WIDTH-1:0]                 x;

  assign x = chain_q[NUM_STAGES-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        chain_q[k] <= RST_VAL;
      end
    end else begin
      chain_q[0] <= ASYNC;
      for (int k = 1; k < NUM_STAGES; k++) begin
        chain_q[k] <= chain_q[k-1];
      end
    end
  end

  // The counter only advances while the synchronized input disagrees with the
  // held level; any return to agreement discards the partial qualification.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= RST_VAL;
      rise_q <= '0;
      fall_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < BUS_WIDTH; i++) begin
        rise_q[i] <= 1'b0;
        fall_q[i] <= 1'b0;
        if (x[i] == sync_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          sync_q[i] <= x[i];
          cnt_q[i]  <= '0;
          rise_q[i] <= x[i];
          fall_q[i] <= ~x[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign SYNC = sync_q;
  assign RISE = rise_q;
  assign FALL = fall_q;

endmodule

// File: tb/tb_bit_sync_filter.sv
// Directed bench for bit_sync_filter: expected {SYNC,RISE,FALL} per cycle are
// queued with each stimulus step and compared after the following clock edge.
module tb_bit_sync_filter;

  localparam int W = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] async_a, async_b, async_c;
  logic [3:0] sync_a, rise_a, fall_a;
  logic [3:0] sync_b, rise_b, fall_b;
  logic [3:0] sync_c, rise_c, fall_c;

  int         sel;
  int         n_assert = 0;
  int         n_fail   = 0;
  string      tag;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  bit_sync_filter #(.BUS_WIDTH(4), .NUM_STAGES(2), .FILTER_LEN(4), .RST_VAL(4'h0)) dut_a (
    .CLK(clk), .RST(rst), .ASYNC(async_a), .SYNC(sync_a), .RISE(rise_a), .FALL(fall_a));

  bit_sync_filter #(.BUS_WIDTH(4), .NUM_STAGES(1), .FILTER_LEN(1), .RST_VAL(4'hF)) dut_b (
    .CLK(clk), .RST(rst), .ASYNC(async_b), .SYNC(sync_b), .RISE(rise_b), .FALL(fall_b));

  bit_sync_filter #(.BUS_WIDTH(4), .NUM_STAGES(3), .FILTER_LEN(8), .RST_VAL(4'hF)) dut_c (
    .CLK(clk), .RST(rst), .ASYNC(async_c), .SYNC(sync_c), .RISE(rise_c), .FALL(fall_c));

  // scoreboard: pop one expectation after the next edge and compare
  task automatic tick_check();
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    @(posedge clk);
    #1;
    case (sel)
      0:       obs = {sync_a, rise_a, fall_a};
      1:       obs = {sync_b, rise_b, fall_b};
      default: obs = {sync_c, rise_c, fall_c};
    endcase
    n_assert++;
    if (exp_q.size() == 0) begin
      assert (1'b0) else begin
        n_fail++;
        $error("FAIL %s scoreboard empty, observed %h", tag, obs);
      end
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s observed sync/rise/fall=%h expected %h", tag, obs, exp);
      end
    end
  endtask

  // driver: apply the selected DUT's input, queue the result for the next edge
  task automatic drive_tick(input logic [3:0] a, input logic [3:0] s,
                            input logic [3:0] r, input logic [3:0] f);
    case (sel)
      0:       async_a = a;
      1:       async_b = a;
      default: async_c = a;
    endcase
    exp_q.push_back({s, r, f});
    tick_check();
  endtask

  initial begin
    sel     = 0;
    rst     = 1'b1;
    async_a = 4'h0;
    async_b = 4'hF;
    async_c = 4'hF;

    tag = "reset";
    for (int e = 0; e < 3; e++) drive_tick(4'h0, 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    tag = "reset_release";
    for (int e = 0; e < 4; e++) drive_tick(4'h0, 4'h0, 4'h0, 4'h0);

    tag = "rise_ch0";
    for (int e = 0; e < 8; e++)
      drive_tick(4'h1, (e >= 5) ? 4'h1 : 4'h0, (e == 5) ? 4'h1 : 4'h0, 4'h0);
    tag = "fall_ch0";
    for (int e = 0; e < 8; e++)
      drive_tick(4'h0, (e < 5) ? 4'h1 : 4'h0, 4'h0, (e == 5) ? 4'h1 : 4'h0);

    tag = "glitch3_ch1";
    for (int e = 0; e < 8; e++)
      drive_tick((e < 3) ? 4'h2 : 4'h0, 4'h0, 4'h0, 4'h0);

    tag = "pulse4_ch1";
    for (int e = 0; e < 11; e++)
      drive_tick((e < 4) ? 4'h2 : 4'h0,
                 (e >= 5 && e <= 8) ? 4'h2 : 4'h0,
                 (e == 5) ? 4'h2 : 4'h0,
                 (e == 9) ? 4'h2 : 4'h0);

    tag = "multi_rise";
    for (int e = 0; e < 7; e++)
      drive_tick(4'hB, (e >= 5) ? 4'hB : 4'h0, (e == 5) ? 4'hB : 4'h0, 4'h0);
    tag = "multi_fall";
    for (int e = 0; e < 7; e++)
      drive_tick(4'h0, (e < 5) ? 4'hB : 4'h0, 4'h0, (e == 5) ? 4'hB : 4'h0);

    tag = "rst_midcount";
    for (int e = 0; e < 3; e++) drive_tick(4'h4, 4'h0, 4'h0, 4'h0);
    rst = 1'b1;
    for (int e = 0; e < 2; e++) drive_tick(4'h4, 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    tag = "requalify";
    for (int e = 0; e < 7; e++)
      drive_tick(4'h4, (e >= 5) ? 4'h4 : 4'h0, (e == 5) ? 4'h4 : 4'h0, 4'h0);
    tag = "requalify_fall";
    for (int e = 0; e < 7; e++)
      drive_tick(4'h0, (e < 5) ? 4'h4 : 4'h0, 4'h0, (e == 5) ? 4'h4 : 4'h0);

    // parameter sweep, reset level all ones
    sel = 1;
    rst = 1'b1;
    tag = "b_reset";
    for (int e = 0; e < 2; e++) drive_tick(4'hF, 4'hF, 4'h0, 4'h0);
    rst = 1'b0;
    tag = "b_release";
    for (int e = 0; e < 3; e++) drive_tick(4'hF, 4'hF, 4'h0, 4'h0);
    tag = "b_fall";
    for (int e = 0; e < 3; e++)
      drive_tick(4'hE, (e >= 1) ? 4'hE : 4'hF, 4'h0, (e == 1) ? 4'h1 : 4'h0);
    tag = "b_rise";
    for (int e = 0; e < 3; e++)
      drive_tick(4'hF, (e >= 1) ? 4'hF : 4'hE, (e == 1) ? 4'h1 : 4'h0, 4'h0);

    sel = 2;
    tag = "c_release";
    for (int e = 0; e < 2; e++) drive_tick(4'hF, 4'hF, 4'h0, 4'h0);
    tag = "c_fall";
    for (int e = 0; e < 12; e++)
      drive_tick(4'h7, (e >= 10) ? 4'h7 : 4'hF, 4'h0, (e == 10) ? 4'h8 : 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
